// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
// Receive-side UART front end: 16x oversampled 8-bit frames with optional parity.
// Detects framing errors and line break.
// Buffers bytes in a first-word-fall-through FIFO behind a valid/ready stream.

module uart_rx_monitor #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              rx_i,
    input  logic [DIV_WIDTH-1:0]              divisor_i,
    input  logic                              parity_en_i,
    input  logic                              parity_odd_i,
    output logic [7:0]                        rx_data_o,
    output logic                              rx_pe_o,
    output logic                              rx_fe_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
    output logic                              overrun_o,
    output logic                              break_o,
    input  logic                              clear_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_s_d;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   presc;
    logic [3:0]             scnt;
    logic [2:0]             bitcnt;
    logic [7:0]             shreg;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   par_bit_q;
    logic                   pe_q;

    logic                   tick;
    logic                   mid_tick;
    logic                   end_tick;
    logic                   fall;
    logic                   push;
    logic [9:0]             push_word;

    logic [9:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic [9:0]             head;

    assign tick      = (presc == (div_q - DIV_ONE));
    assign mid_tick  = tick && (scnt == 4'd7);
    assign end_tick  = tick && (scnt == 4'd15);
    assign fall      = rx_s_d && !rx_s;
    assign push      = (state == ST_STOP) && mid_tick;
    assign push_word = {pe_q, ~rx_s, shreg};

    assign full   = (count == FULL_CNT);
    assign pop    = rx_valid_o && rx_ready_i;
    assign wr_en  = push && (!full || pop);
    assign head   = mem[rd_ptr];

    // Two-flop synchroniser plus one delayed copy for start-edge detection; idle line is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Frame FSM with prescaler, 16x sample counter, shift register and registered break pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            div_q     <= DIV_ONE;
            presc     <= '0;
            scnt      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
            break_o   <= 1'b0;
        end else begin
            break_o <= 1'b0;
            if (state != ST_IDLE && state != ST_BREAK) begin
                if (tick) begin
                    presc <= '0;
                    scnt  <= scnt + 4'd1;
                end else begin
                    presc <= presc + DIV_ONE;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        presc     <= '0;
                        scnt      <= '0;
                        bitcnt    <= '0;
                        div_q     <= (divisor_i == '0) ? DIV_ONE : divisor_i;
                        par_en_q  <= parity_en_i;
                        par_odd_q <= parity_odd_i;
                        par_bit_q <= 1'b0;
                        pe_q      <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_tick && rx_s) begin
                        state <= ST_IDLE;
                    end else if (end_tick) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                    end
                    if (end_tick) begin
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid_tick) begin
                        par_bit_q <= rx_s;
                        pe_q      <= ((^shreg) ^ rx_s) != par_odd_q;
                    end
                    if (end_tick) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (mid_tick) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else if (shreg == 8'h00 && !par_bit_q) begin
                            break_o <= 1'b1;
                            state   <= ST_BREAK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the outputs are masked while empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and sticky overrun (a set beats a simultaneous clear)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_en && !pop) begin
                count <= count + CNT_ONE;
            end else if (!wr_en && pop) begin
                count <= count - CNT_ONE;
            end
            if (push && full && !pop) begin
                overrun_o <= 1'b1;
            end else if (clear_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    // First-word-fall-through view of the head entry, zero while empty
    always_comb begin
        rx_valid_o   = (count != '0);
        fifo_count_o = count;
        rx_data_o    = 8'h00;
        rx_pe_o      = 1'b0;
        rx_fe_o      = 1'b0;
        if (rx_valid_o) begin
            rx_data_o = head[7:0];
            rx_fe_o   = head[8];
            rx_pe_o   = head[9];
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor
// Drives serial frames into uart_rx_monitor and compares FIFO contents, flags and pulses
// against a queue-based model built from frame contents.

module tb_uart_rx_monitor;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           rx_i = 1'b1;
    logic [DW-1:0]  divisor_i = 16'd1;
    logic           parity_en_i = 1'b0;
    logic           parity_odd_i = 1'b0;
    logic [7:0]     rx_data_o;
    logic           rx_pe_o;
    logic           rx_fe_o;
    logic           rx_valid_o;
    logic           rx_ready_i = 1'b0;
    logic [CW-1:0]  fifo_count_o;
    logic           overrun_o;
    logic           break_o;
    logic           clear_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int break_cnt = 0;
    int valid_rise_cyc = -1;
    int meas_lat = 155;
    logic valid_prev = 1'b0;

    logic [9:0] model_q[$];
    logic       model_ovr = 1'b0;

    uart_rx_monitor #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_i         (rx_i),
        .divisor_i    (divisor_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .rx_data_o    (rx_data_o),
        .rx_pe_o      (rx_pe_o),
        .rx_fe_o      (rx_fe_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .fifo_count_o (fifo_count_o),
        .overrun_o    (overrun_o),
        .break_o      (break_o),
        .clear_i      (clear_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count break pulses and note when rx_valid_o rises, sampled mid-cycle
    always @(negedge clk) begin
        if (break_o === 1'b1) break_cnt++;
        if (rx_valid_o === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
        valid_prev = rx_valid_o;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected FIFO entry {pe, fe, data} for a frame, from the parity/stop rules
    function automatic logic [9:0] frame_entry(input logic [7:0] data, input logic pen,
                                               input logic podd, input logic pbit, input logic stop);
        logic pe;
        pe = pen && ((($countones(data) + int'(pbit)) % 2) != int'(podd));
        return {pe, ~stop, data};
    endfunction

    function automatic logic frame_is_break(input logic [7:0] data, input logic pen,
                                            input logic pbit, input logic stop);
        return !stop && (data == 8'h00) && (!pen || !pbit);
    endfunction

    function automatic void model_push(input logic [9:0] e);
        if (model_q.size() < DEPTH) model_q.push_back(e);
        else model_ovr = 1'b1;
    endfunction

    // One complete frame at 16*div clocks per bit, followed by two idle bit times
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                              input logic pbit, input logic stop, input int div);
        int bt;
        bt = 16 * ((div == 0) ? 1 : div);
        divisor_i    = DW'(div);
        parity_en_i  = pen;
        parity_odd_i = podd;
        rx_i = 1'b0;
        hold(bt);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            hold(bt);
        end
        if (pen) begin
            rx_i = pbit;
            hold(bt);
        end
        rx_i = stop;
        hold(bt);
        rx_i = 1'b1;
        hold(2 * bt);
    endtask

    task automatic pop_one(output logic [9:0] obs);
        obs = {rx_pe_o, rx_fe_o, rx_data_o};
        rx_ready_i = 1'b1;
        hold(1);
        rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        hold(2);
        checks++;
        if (rx_valid_o !== 1'b0 || fifo_count_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_fifo: got valid=%b count=%0d expected valid=0 count=0", rx_valid_o, fifo_count_o);
        end
        checks++;
        if ({rx_pe_o, rx_fe_o, rx_data_o} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_head: got %h expected 000", {rx_pe_o, rx_fe_o, rx_data_o});
        end
        checks++;
        if (overrun_o !== 1'b0 || break_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ovr=%b brk=%b expected 0 0", overrun_o, break_o);
        end
        rstn = 1'b1;
        hold(2);
    endtask

    task automatic test_basic();
        int start_cyc;
        logic [9:0] obs;
        logic [9:0] exp_e;
        model_q.delete();
        start_cyc = cyc;
        valid_rise_cyc = -1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        model_push(frame_entry(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
        checks++;
        if (valid_rise_cyc < 0 || (valid_rise_cyc - start_cyc) < 150 || (valid_rise_cyc - start_cyc) > 160) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d clk expected 150..160", valid_rise_cyc - start_cyc);
        end else begin
            meas_lat = valid_rise_cyc - start_cyc;
        end
        checks++;
        if (fifo_count_o !== CW'(model_q.size())) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d expected %0d", fifo_count_o, model_q.size());
        end
        while (model_q.size() > 0) begin
            pop_one(obs);
            exp_e = model_q.pop_front();
            checks++;
            if (obs !== exp_e) begin
                errors++;
                $display("[TB] FAIL basic_head: got %h expected %h", obs, exp_e);
            end
        end
        checks++;
        if (rx_valid_o !== 1'b0 || fifo_count_o !== '0) begin
            errors++;
            $display("[TB] FAIL basic_empty: got valid=%b count=%0d expected 0 0", rx_valid_o, fifo_count_o);
        end
    endtask

    task automatic test_parity();
        logic [9:0] obs;
        logic [9:0] exp_e;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        model_push(frame_entry(8'h01, 1'b1, 1'b1, 1'b1, 1'b1));
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        model_push(frame_entry(8'h01, 1'b1, 1'b1, 1'b0, 1'b1));
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        model_push(frame_entry(8'h03, 1'b1, 1'b0, 1'b1, 1'b1));
        checks++;
        if (fifo_count_o !== CW'(model_q.size())) begin
            errors++;
            $display("[TB] FAIL parity_count: got %0d expected %0d", fifo_count_o, model_q.size());
        end
        while (model_q.size() > 0) begin
            pop_one(obs);
            exp_e = model_q.pop_front();
            checks++;
            if (obs !== exp_e) begin
                errors++;
                $display("[TB] FAIL parity_head: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [9:0] obs;
        logic [9:0] exp_e;
        divisor_i = 16'd1;
        rx_i = 1'b0;
        hold(4);
        rx_i = 1'b1;
        hold(64);
        checks++;
        if (fifo_count_o !== '0 || rx_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_nopush: got count=%0d valid=%b expected 0 0", fifo_count_o, rx_valid_o);
        end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        model_push(frame_entry(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1));
        while (model_q.size() > 0) begin
            pop_one(obs);
            exp_e = model_q.pop_front();
            checks++;
            if (obs !== exp_e) begin
                errors++;
                $display("[TB] FAIL glitch_next_frame: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    task automatic test_framing_break();
        int bc0;
        logic [9:0] obs;
        logic [9:0] exp_e;
        bc0 = break_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        model_push(frame_entry(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        checks++;
        if (break_cnt !== bc0) begin
            errors++;
            $display("[TB] FAIL fe_no_break: got %0d pulses expected %0d", break_cnt - bc0, 0);
        end
        divisor_i = 16'd1;
        rx_i = 1'b0;
        hold(20 * 16);
        model_push({1'b0, 1'b1, 8'h00});
        checks++;
        if (fifo_count_o !== CW'(model_q.size())) begin
            errors++;
            $display("[TB] FAIL break_single_entry: got %0d expected %0d", fifo_count_o, model_q.size());
        end
        rx_i = 1'b1;
        hold(64);
        checks++;
        if (break_cnt - bc0 !== 1 || fifo_count_o !== CW'(model_q.size())) begin
            errors++;
            $display("[TB] FAIL break_pulse: got pulses=%0d count=%0d expected 1 %0d", break_cnt - bc0, fifo_count_o, model_q.size());
        end
        while (model_q.size() > 0) begin
            pop_one(obs);
            exp_e = model_q.pop_front();
            checks++;
            if (obs !== exp_e) begin
                errors++;
                $display("[TB] FAIL break_head: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    task automatic test_overrun();
        logic [9:0] obs;
        logic [9:0] exp_e;
        rx_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1);
            model_push(frame_entry(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1));
        end
        checks++;
        if (fifo_count_o !== CW'(model_q.size()) || overrun_o !== model_ovr) begin
            errors++;
            $display("[TB] FAIL overrun_full: got count=%0d ovr=%b expected %0d %b", fifo_count_o, overrun_o, model_q.size(), model_ovr);
        end
        while (model_q.size() > 0) begin
            pop_one(obs);
            exp_e = model_q.pop_front();
            checks++;
            if (obs !== exp_e) begin
                errors++;
                $display("[TB] FAIL overrun_head: got %h expected %h", obs, exp_e);
            end
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun_o);
        end
        clear_i = 1'b1;
        hold(1);
        clear_i = 1'b0;
        model_ovr = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", overrun_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat_use;
        logic [9:0] obs_pop;
        logic [9:0] exp_e;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1);
            model_push(frame_entry(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1));
        end
        checks++;
        if (fifo_count_o !== 3'(DEPTH) || overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_fill: got count=%0d ovr=%b expected %0d 0", fifo_count_o, overrun_o, DEPTH);
        end
        lat_use = meas_lat;
        obs_pop = '0;
        fork
            send_frame(8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 1);
            begin
                hold(lat_use - 1);
                obs_pop = {rx_pe_o, rx_fe_o, rx_data_o};
                rx_ready_i = 1'b1;
                hold(1);
                rx_ready_i = 1'b0;
            end
        join
        exp_e = model_q.pop_front();
        model_push(frame_entry(8'h24, 1'b0, 1'b0, 1'b0, 1'b1));
        checks++;
        if (obs_pop !== exp_e) begin
            errors++;
            $display("[TB] FAIL b2b_popped: got %h expected %h", obs_pop, exp_e);
        end
        checks++;
        if (fifo_count_o !== CW'(model_q.size()) || overrun_o !== model_ovr) begin
            errors++;
            $display("[TB] FAIL b2b_simul: got count=%0d ovr=%b expected %0d %b", fifo_count_o, overrun_o, model_q.size(), model_ovr);
        end
        checks++;
        if ({rx_pe_o, rx_fe_o, rx_data_o} !== model_q[0]) begin
            errors++;
            $display("[TB] FAIL b2b_new_head: got %h expected %h", {rx_pe_o, rx_fe_o, rx_data_o}, model_q[0]);
        end
        send_frame(8'h25, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        model_push(frame_entry(8'h25, 1'b0, 1'b0, 1'b0, 1'b1));
        checks++;
        if (overrun_o !== model_ovr || fifo_count_o !== CW'(model_q.size())) begin
            errors++;
            $display("[TB] FAIL b2b_overrun: got ovr=%b count=%0d expected %b %0d", overrun_o, fifo_count_o, model_ovr, model_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
            begin
                hold(16 * 6 + 8);
                rstn = 1'b0;
                hold(1);
                checks++;
                if (rx_valid_o !== 1'b0 || fifo_count_o !== '0 || {rx_pe_o, rx_fe_o, rx_data_o} !== 10'h000) begin
                    errors++;
                    $display("[TB] FAIL midreset_fifo: got valid=%b count=%0d head=%h expected 0 0 000", rx_valid_o, fifo_count_o, {rx_pe_o, rx_fe_o, rx_data_o});
                end
                checks++;
                if (overrun_o !== 1'b0 || break_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midreset_flags: got ovr=%b brk=%b expected 0 0", overrun_o, break_o);
                end
                rstn = 1'b1;
            end
        join
        model_q.delete();
        model_ovr = 1'b0;
        hold(32);
        checks++;
        if (rx_valid_o !== 1'b0 || fifo_count_o !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_no_partial: got valid=%b count=%0d expected 0 0", rx_valid_o, fifo_count_o);
        end
    endtask

    task automatic test_random();
        int n;
        int bc0;
        int exp_breaks;
        int div;
        logic [7:0] data;
        logic pen, podd, pbit, stop;
        logic [9:0] obs;
        logic [9:0] exp_e;
        for (int b = 0; b < 4; b++) begin
            n = $urandom_range(1, 5);
            bc0 = break_cnt;
            exp_breaks = 0;
            for (int k = 0; k < n; k++) begin
                data = 8'($urandom);
                if ($urandom_range(0, 5) == 0) data = 8'h00;
                pen  = 1'($urandom);
                podd = 1'($urandom);
                pbit = 1'($urandom);
                stop = ($urandom_range(0, 3) != 0);
                div  = $urandom_range(0, 3);
                send_frame(data, pen, podd, pbit, stop, div);
                model_push(frame_entry(data, pen, podd, pbit, stop));
                if (frame_is_break(data, pen, pbit, stop)) exp_breaks++;
            end
            checks++;
            if (fifo_count_o !== CW'(model_q.size()) || overrun_o !== model_ovr) begin
                errors++;
                $display("[TB] FAIL rand_state: got count=%0d ovr=%b expected %0d %b", fifo_count_o, overrun_o, model_q.size(), model_ovr);
            end
            checks++;
            if (break_cnt - bc0 !== exp_breaks) begin
                errors++;
                $display("[TB] FAIL rand_breaks: got %0d expected %0d", break_cnt - bc0, exp_breaks);
            end
            while (model_q.size() > 0) begin
                pop_one(obs);
                exp_e = model_q.pop_front();
                checks++;
                if (obs !== exp_e) begin
                    errors++;
                    $display("[TB] FAIL rand_head: got %h expected %h", obs, exp_e);
                end
            end
            clear_i = 1'b1;
            hold(1);
            clear_i = 1'b0;
            model_ovr = 1'b0;
        end
    endtask

    initial begin
        hold(1);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_framing_break();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
